// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared register map, status bits and TX FSM encodings for mmio_uart_tx
package mmio_uart_tx_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFD0_0000;

   // Register select is daddr[3:2]
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;
   localparam logic [1:0] REG_RSVD    = 2'd3;

   localparam int STAT_FULL   = 1;
   localparam int STAT_EMPTY  = 2;
   localparam int STAT_BUSY   = 3;
   localparam int STAT_OVF    = 4;
   localparam int STAT_PARITY = 5;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // A bit time shorter than two cycles cannot be counted, so small values are raised to 2
   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < 16'd2) ? 16'd2 : v;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; a push while full is taken only if a pop frees a slot
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Storage array; contents need no reset because the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Read/write pointers with a wrap bit to tell full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped FIFO-buffered UART transmitter; MMIO_UART_PARITY_EN selects 8E1 framing
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] CLK_DIV    = 16'd434
) (
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic [31:0] daddr,
   input  logic        dce,
   input  logic [3:0]  we,
   input  logic [31:0] din,
   output logic [31:0] dm,
   output logic        mmio_hit,
   output logic        uart_txd
);

`ifdef MMIO_UART_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
`else
   localparam logic PARITY_FLAG = 1'b0;
`endif

   logic                        hit;
   logic [1:0]                  reg_sel;
   logic                        rd_en;
   logic                        push_req;
   logic                        pop;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [7:0]                  fifo_dout;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [15:0]                 divisor;
   logic [15:0]                 div_wr_val;
   logic                        div_we;
   logic                        ovf;
   logic                        ovf_set;
   logic                        ovf_clr;
   logic                        busy;
   logic [31:0]                 status;
   logic [31:0]                 rd_data;
   logic [2:0]                  state;
   logic [15:0]                 frame_div;
   logic [15:0]                 baud_cnt;
   logic                        baud_done;
   logic [2:0]                  bit_idx;
   logic [7:0]                  shreg;
   logic                        unused_bits;

   assign hit        = dce & (daddr[31:4] == BASE_ADDR[31:4]);
   assign reg_sel    = daddr[3:2];
   assign rd_en      = hit & (we == 4'b0000);
   assign push_req   = hit & (reg_sel == REG_TXDATA) & we[0];
   assign pop        = (state == ST_IDLE) & ~fifo_empty;
   assign ovf_set    = push_req & fifo_full & ~pop;
   assign ovf_clr    = rd_en & (reg_sel == REG_STATUS);
   assign busy       = (state != ST_IDLE) | ~fifo_empty;
   assign div_we     = hit & (reg_sel == REG_DIVISOR) & (we[1] | we[0]);
   assign div_wr_val = clamp_div({we[1] ? din[15:8] : divisor[15:8],
                                  we[0] ? din[7:0]  : divisor[7:0]});
   assign baud_done  = (baud_cnt == frame_div - 16'd1);
   assign unused_bits = &{1'b0, daddr[1:0], din[31:16], fifo_count};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (cpu_clk_50M),
      .rst   (cpu_rst),
      .push  (push_req),
      .pop   (pop),
      .din   (din[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // STATUS word and the read-data mux for the addressed register
   always_comb begin
      status              = '0;
      status[STAT_FULL]   = fifo_full;
      status[STAT_EMPTY]  = fifo_empty;
      status[STAT_BUSY]   = busy;
      status[STAT_OVF]    = ovf;
      status[STAT_PARITY] = PARITY_FLAG;
      case (reg_sel)
         REG_STATUS:  rd_data = status;
         REG_DIVISOR: rd_data = {16'd0, divisor};
         REG_RSVD:    rd_data = 32'd0;
         default:     rd_data = 32'd0;
      endcase
   end

   // Bus-visible registers: divisor, sticky overflow flag, registered read data and hit
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         divisor  <= CLK_DIV;
         ovf      <= 1'b0;
         dm       <= 32'd0;
         mmio_hit <= 1'b0;
      end else begin
         if (div_we) divisor <= div_wr_val;
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         mmio_hit <= hit;
         dm       <= rd_en ? rd_data : 32'd0;
      end
   end

   // Baud counter: runs 0..frame_div-1 in every non-idle state, restarting each bit
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst)                          baud_cnt <= 16'd0;
      else if (state == ST_IDLE || baud_done) baud_cnt <= 16'd0;
      else                                  baud_cnt <= baud_cnt + 16'd1;
   end

   // TX FSM: the divisor is latched at pop so mid-frame DIVISOR writes apply to the next frame
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         state     <= ST_IDLE;
         frame_div <= CLK_DIV;
         bit_idx   <= 3'd0;
         shreg     <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  shreg     <= fifo_dout;
                  frame_div <= divisor;
                  bit_idx   <= 3'd0;
                  state     <= ST_START;
               end
            end
            ST_START: if (baud_done) state <= ST_DATA;
            ST_DATA: begin
               if (baud_done) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end
            end
            // Only entered in 8E1 builds
            ST_PARITY: if (baud_done) state <= ST_STOP;
            ST_STOP:   if (baud_done) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Serial line level decoded from the FSM; reset forces IDLE and hence a high line at once
   always_comb begin
      case (state)
         ST_START:  uart_txd = 1'b0;
         ST_DATA:   uart_txd = shreg[bit_idx];
         ST_PARITY: uart_txd = ^shreg;
         default:   uart_txd = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx with a frame-level line model
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'hBFD0_0000;
   localparam logic [31:0] A_TX  = BASE;
   localparam logic [31:0] A_ST  = BASE + 32'd4;
   localparam logic [31:0] A_DIV = BASE + 32'd8;
   localparam logic [31:0] A_RSV = BASE + 32'd12;
`ifdef MMIO_UART_PARITY_EN
   localparam logic [31:0] PAR_BIT = 32'h20;
`else
   localparam logic [31:0] PAR_BIT = 32'h0;
`endif

   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst     = 1'b1;
   logic [31:0] daddr       = 32'd0;
   logic        dce         = 1'b0;
   logic [3:0]  we          = 4'd0;
   logic [31:0] din         = 32'd0;
   logic [31:0] dm;
   logic        mmio_hit;
   logic        uart_txd;

   int total = 0;
   int bad   = 0;

   // Expected frames, each {divisor, byte}, in transmit order
   logic [23:0] exp_q[$];
   logic [15:0] model_div = 16'd434;
   bit          mon_en    = 1'b1;
   bit          mon_busy  = 1'b0;

   mmio_uart_tx dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst     (cpu_rst),
      .daddr       (daddr),
      .dce         (dce),
      .we          (we),
      .din         (din),
      .dm          (dm),
      .mmio_hit    (mmio_hit),
      .uart_txd    (uart_txd)
   );

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic bus_set(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      @(negedge cpu_clk_50M);
      daddr = a; dce = 1'b1; we = w; din = d;
   endtask

   task automatic bus_idle();
      @(negedge cpu_clk_50M);
      dce = 1'b0; we = 4'd0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      bus_set(a, w, d);
      bus_idle();
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      bus_set(a, 4'd0, 32'd0);
      bus_idle();
      d = dm;
      h = mmio_hit;
   endtask

   task automatic wr_div(input logic [31:0] v);
      bus_write(A_DIV, 4'b0011, v);
      model_div = (v[15:0] < 16'd2) ? 16'd2 : v[15:0];
   endtask

   task automatic wr_byte(input logic [7:0] b);
      bus_write(A_TX, 4'b0001, {24'd0, b});
      exp_q.push_back({model_div, b});
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
         @(negedge cpu_clk_50M);
         n++;
      end
      check_eq("drain_in_time", {31'd0, n < budget}, 32'd1);
      repeat (3) @(negedge cpu_clk_50M);
   endtask

   // Line monitor: every frame must hold each bit level for exactly divisor cycles, then idle high
   initial begin : monitor
      logic [23:0] item;
      logic [15:0] d;
      logic [7:0]  b;
      logic [10:0] bits;
      int          nb;
      bit          ok;
      int          to;
      forever begin
         @(negedge cpu_clk_50M);
         if (mon_en && !cpu_rst && uart_txd == 1'b0) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_start", {31'd0, uart_txd}, 32'd1);
               to = 0;
               while (uart_txd == 1'b0 && to < 5000) begin
                  @(negedge cpu_clk_50M);
                  to++;
               end
            end else begin
               mon_busy = 1'b1;
               item = exp_q.pop_front();
               d = item[23:8];
               b = item[7:0];
`ifdef MMIO_UART_PARITY_EN
               nb   = 11;
               bits = {1'b1, ^b, b, 1'b0};
`else
               nb   = 10;
               bits = {1'b0, 1'b1, b, 1'b0};
`endif
               for (int k = 0; k < nb; k++) begin
                  ok = 1'b1;
                  for (int c = 0; c < int'(d); c++) begin
                     if (k != 0 || c != 0) @(negedge cpu_clk_50M);
                     if (uart_txd !== bits[k]) ok = 1'b0;
                  end
                  check_eq($sformatf("frame_%02h_div%0d_bit%0d", b, d, k), {31'd0, ok}, 32'd1);
               end
               @(negedge cpu_clk_50M);
               check_eq("gap_idle", {31'd0, uart_txd}, 32'd1);
               mon_busy = 1'b0;
            end
         end
      end
   end

   initial begin : main
      logic [31:0] rd;
      logic        h;
      int          lows;
      int          nbytes;

      // Reset state
      repeat (2) @(negedge cpu_clk_50M);
      check_eq("rst_txd", {31'd0, uart_txd}, 32'd1);
      check_eq("rst_dm", dm, 32'd0);
      check_eq("rst_hit", {31'd0, mmio_hit}, 32'd0);
      cpu_rst = 1'b0;

      bus_read(A_ST, rd, h);
      check_eq("status_after_reset", rd, 32'h4 | PAR_BIT);
      check_eq("status_hit", {31'd0, h}, 32'd1);
      check_eq("status_txd", {31'd0, uart_txd}, 32'd1);
      bus_read(A_DIV, rd, h);
      check_eq("div_reset", rd, 32'd434);
      bus_read(A_TX, rd, h);
      check_eq("txdata_reads_zero", rd, 32'd0);
      bus_read(A_RSV, rd, h);
      check_eq("rsvd_reads_zero", rd, 32'd0);

      // 0xA5 at divisor 4: 40-cycle frame
      wr_div(32'd4);
      bus_read(A_DIV, rd, h);
      check_eq("div_rd_4", rd, 32'd4);
      wr_byte(8'hA5);
      check_eq("dm_zero_after_write", dm, 32'd0);
      check_eq("hit_after_write", {31'd0, mmio_hit}, 32'd1);
      wait_idle(500);

      // Divisor change while a frame is in flight applies only to the following frame
      wr_byte(8'h3C);
      wr_div(32'd6);
      wr_byte(8'hC3);
      wait_idle(500);

      // Overflow: 17 accepted at divisor 100, the 18th is dropped
      wr_div(32'd100);
      for (int i = 0; i < 18; i++) begin
         bus_set(A_TX, 4'b0001, 32'(8'h10 + i));
         if (i < 17) exp_q.push_back({model_div, 8'(8'h10 + i)});
      end
      bus_read(A_ST, rd, h);
      check_eq("status_ovf_set", rd, 32'h1A | PAR_BIT);
      bus_read(A_ST, rd, h);
      check_eq("status_ovf_cleared", rd, 32'h0A | PAR_BIT);
      wait_idle(30000);
      bus_read(A_ST, rd, h);
      check_eq("status_empty_after_ovf", rd, 32'h4 | PAR_BIT);

      // Divisor clamping and byte-lane writes
      wr_div(32'd0);
      bus_read(A_DIV, rd, h);
      check_eq("div_clamp0", rd, 32'd2);
      wr_byte(8'h5A);
      wait_idle(200);
      bus_write(A_DIV, 4'b0010, 32'h0000_0100);
      model_div = 16'h0102;
      bus_read(A_DIV, rd, h);
      check_eq("div_upper_lane", rd, 32'h102);
      bus_write(A_RSV, 4'b1111, 32'hFFFF_FFFF);
      bus_read(A_DIV, rd, h);
      check_eq("rsvd_write_ignored", rd, 32'h102);
      bus_write(A_TX, 4'b0010, 32'h0000_FF00);
      bus_read(A_ST, rd, h);
      check_eq("no_push_without_we0", rd, 32'h4 | PAR_BIT);

      // Randomized batches
      for (int batch = 0; batch < 8; batch++) begin
         wr_div(32'($urandom_range(0, 9)));
         bus_read(A_DIV, rd, h);
         check_eq("div_rand", rd, {16'd0, model_div});
         nbytes = $urandom_range(1, 5);
         for (int j = 0; j < nbytes; j++) begin
            wr_byte(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge cpu_clk_50M);
         end
         wait_idle(2000);
         bus_read(A_ST, rd, h);
         check_eq("status_rand_idle", rd, 32'h4 | PAR_BIT);
      end

      // Reset in the middle of DATA
      wr_div(32'd8);
      mon_en = 1'b0;
      for (int j = 0; j < 3; j++) bus_write(A_TX, 4'b0001, 32'h0);
      repeat (20) @(negedge cpu_clk_50M);
      check_eq("txd_low_in_data", {31'd0, uart_txd}, 32'd0);
      cpu_rst = 1'b1;
      #1;
      check_eq("txd_async_reset", {31'd0, uart_txd}, 32'd1);
      repeat (2) @(negedge cpu_clk_50M);
      cpu_rst = 1'b0;
      model_div = 16'd434;
      bus_read(A_ST, rd, h);
      check_eq("status_after_midreset", rd, 32'h4 | PAR_BIT);
      bus_read(A_DIV, rd, h);
      check_eq("div_after_midreset", rd, 32'd434);
      lows = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge cpu_clk_50M);
         if (uart_txd !== 1'b1) lows++;
      end
      check_eq("no_residual_frame", 32'(lows), 32'd0);
      mon_en = 1'b1;

      // Address misses and the 0x07 frame (parity bit 1 in 8E1 builds)
      bus_read(BASE + 32'h20, rd, h);
      check_eq("miss_hit", {31'd0, h}, 32'd0);
      check_eq("miss_dm", rd, 32'd0);
      bus_write(BASE + 32'h10, 4'b0001, 32'h55);
      bus_read(A_ST, rd, h);
      check_eq("miss_write_no_push", rd, 32'h4 | PAR_BIT);
      wr_div(32'd3);
      wr_byte(8'h07);
      wait_idle(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
